imm_extend_stage: RTL and testbench
===================================

Name: imm_extend_stage

Overview:
Parametrised, buffered successor to the decode-stage sign extender. It takes an instruction word and an extension mode (zero, sign, LUI, branch-offset) over a valid/ready handshake, computes the extended immediate and holds results in a small FIFO. Results are presented to the execute side as registered outputs, which removes the extender from the decode critical path. Sits between the decode latch and the ALU operand mux. Supports flush on branch mispredict.

Parameters:
WORD_W, 32, datapath/instruction width in bits
IMM_W, 16, immediate field width; instr[IMM_W-1:0] is the immediate; WORD_W >= IMM_W+2 is required
DEPTH, 2, result buffer entries (>=1, need not be a power of 2)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
flush  in  1  discard all buffered and incoming entries
in_valid  in  1  instruction/mode present
in_ready  out  1  buffer can accept this cycle
instr  in  WORD_W  instruction word
mode  in  2  ext_mode_t: EXT_ZERO=0, EXT_SIGN=1, EXT_LUI=2, EXT_BRANCH=3
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes head this cycle
ext_imm  out  WORD_W  extended immediate of head entry
ext_mode  out  2  mode of head entry
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Push = in_valid & in_ready & !flush. Pop = out_valid & out_ready & !flush.
- in_ready = (count < DEPTH). It depends only on registered state, with no combinational path from out_ready. When count==DEPTH, a simultaneous pop does not allow a push in that cycle.
- out_valid = (count != 0). ext_imm and ext_mode come from buffer[rd_ptr]. When empty they hold their last value; reset value is 0.
- Extension is computed at push time and stored. Let imm = instr[IMM_W-1:0]:
  EXT_ZERO: {(WORD_W-IMM_W) zeros, imm}
  EXT_SIGN: {(WORD_W-IMM_W) copies of imm[IMM_W-1], imm}
  EXT_LUI: imm placed in the top IMM_W bits, lower bits zero (WORD_W=32, IMM_W=16 gives {imm,16'h0})
  EXT_BRANCH: sign-extend, then shift left 2. The top 2 bits of the sign-extended value are dropped; no overflow flag.
- Latency: an entry pushed at edge N has out_valid=1 after edge N, so it is visible in cycle N+1. Minimum 1 cycle; no bypass.
- Pointers: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
- Ordering: strict FIFO.
- Flush: at the next edge count, wr_ptr and rd_ptr are set to 0. A concurrent push is dropped and a concurrent pop is not counted. Flush beats push and pop. Buffer data contents are not cleared.
- Reset (nRST low, asynchronous, at any time including mid-transfer): count=0, pointers=0, out_valid=0, in_ready=1 (DEPTH>=1), ext_imm=0, ext_mode=EXT_ZERO, buffer cleared to 0.
- Out-of-range mode is impossible (2-bit enum fully decoded).

Decomposition:
- cpu_types_pkg: add typedef enum logic [1:0] ext_mode_t {EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BRANCH}. Add typedef struct packed {word_t imm; ext_mode_t mode;} ext_entry_t for the default width.
- Sub-module imm_extend_core: purely combinational; instr, mode in; extended word out. Parametrised by WORD_W and IMM_W, and reusable by the single-cycle datapath.
- imm_extend_stage instantiates the core and implements the buffer, pointers and handshake.
- Add an interface file imm_extend_if.vh with modports ies (block) and tb (bench).

Test Plan:
- Extension modes, out_ready=1:
  - instr=0x2401FFFC, EXT_SIGN -> ext_imm=0xFFFFFFFC one cycle later.
  - Same instr, EXT_ZERO -> 0x0000FFFC.
  - instr=0x3C011234, EXT_LUI -> 0x12340000.
  - instr=0x1000FFFF, EXT_BRANCH -> 0xFFFFFFFC.
  - instr=0x10007FFF, EXT_BRANCH -> 0x0001FFFC.
- Fill/backpressure, DEPTH=2, out_ready=0: push 3 back-to-back valid instrs -> in_ready=0 after 2nd push, count=2, 3rd not accepted. Raise out_ready -> entries emerge in order, in_ready=1 the cycle after the first pop.
- Streaming with out_ready=1 and in_valid=1 every cycle for 10 cycles -> throughput 1/cycle, count stays 1, values in order.
- Flush with count=2 and a simultaneous in_valid -> next cycle count=0, out_valid=0, the incoming entry is lost. The next push appears with 1-cycle latency.
- Reset asserted asynchronously mid-stream (count=1, between edges) -> out_valid=0, count=0, ext_imm=0 immediately. After release, the first push at the next edge is output correctly.
- Parameter sweep: WORD_W=64, IMM_W=12, DEPTH=3, imm=0x800, EXT_SIGN -> 0xFFFFFFFFFFFFF800. Pointer wrap across 7 pushes/pops keeps FIFO order.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the default word, immediate extension modes and
// the buffered extender entry layout.
package cpu_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'd0,
        EXT_SIGN   = 2'd1,
        EXT_LUI    = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_mode_t;

    typedef struct packed {
        word_t     imm;
        ext_mode_t mode;
    } ext_entry_t;

endpackage

// File: rtl/imm_extend_if.sv
// Bundle of the buffered immediate extender handshake; the block takes the
// ies view and a bench or driver takes the tb view.
interface imm_extend_if
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2
) (
    input logic CLK,
    input logic nRST
);

    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [WORD_W-1:0]            instr;
    ext_mode_t                    mode;
    logic                         out_valid;
    logic                         out_ready;
    logic [WORD_W-1:0]            ext_imm;
    ext_mode_t                    ext_mode;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport ies (
        input  CLK, nRST, flush, in_valid, instr, mode, out_ready,
        output in_ready, out_valid, ext_imm, ext_mode, count
    );

    modport tb (
        input  CLK, nRST, in_ready, out_valid, ext_imm, ext_mode, count,
        output flush, in_valid, instr, mode, out_ready
    );

endinterface

// File: rtl/imm_extend_core.sv
// Purely combinational immediate extender, shared by the buffered stage and
// the single-cycle datapath.
module imm_extend_core
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [WORD_W-1:0] instr,
    input  ext_mode_t         mode,
    output logic [WORD_W-1:0] ext_imm
);

    logic [IMM_W-1:0]  imm;
    logic [WORD_W-1:0] sext;
    logic              unusedHighBits;

    assign imm            = instr[IMM_W-1:0];
    assign sext           = {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign unusedHighBits = ^instr[WORD_W-1:IMM_W];

    // Branch offsets are word-aligned, so the two top sign bits fall off.
    always_comb begin
        ext_imm = '0;
        unique case (mode)
            EXT_ZERO:   ext_imm = {{(WORD_W-IMM_W){1'b0}}, imm};
            EXT_SIGN:   ext_imm = sext;
            EXT_LUI:    ext_imm = {imm, {(WORD_W-IMM_W){1'b0}}};
            EXT_BRANCH: ext_imm = {sext[WORD_W-3:0], 2'b00};
            default:    ext_imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Buffered immediate extender: results are computed on push and held in a
// small FIFO so the execute side sees registered operands.
module imm_extend_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int IMM_W  = 16,
    parameter int DEPTH  = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W-1:0]          instr,
    input  ext_mode_t                  mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          ext_imm,
    output ext_mode_t                  ext_mode,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] imm_q  [DEPTH];
    ext_mode_t         mode_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] coreImm;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    imm_extend_core #(
        .WORD_W (WORD_W),
        .IMM_W  (IMM_W)
    ) u_core (
        .instr   (instr),
        .mode    (mode),
        .ext_imm (coreImm)
    );

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign ext_imm   = imm_q[rdPtr_q];
    assign ext_mode  = mode_q[rdPtr_q];
    assign count     = count_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = nextPtr(wrPtr_q);
            if (pop)  rdPtr_d = nextPtr(rdPtr_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i]  <= '0;
                mode_q[i] <= EXT_ZERO;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (push) begin
                imm_q[wrPtr_q]  <= coreImm;
                mode_q[wrPtr_q] <= mode;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboard bench for imm_extend_stage: a default 32/16/2 instance and a
// 64/12/3 instance share stimulus, each with its own arithmetic reference model.
module tb_imm_extend_stage;
    import cpu_types_pkg::*;

    localparam int DEPTH_A = 2;
    localparam int DEPTH_B = 3;

    typedef struct {
        logic [63:0] imm;
        logic [1:0]  mode;
    } exp_t;

    logic        CLK;
    logic        nRST;
    logic [63:0] instrB;
    logic        inReadyB, outValidB;
    logic [63:0] extImmB;
    ext_mode_t   extModeB;
    logic [1:0]  countB;

    exp_t qA[$];
    exp_t qB[$];
    int   checks = 0;
    int   errors = 0;

    imm_extend_if #(.WORD_W(32), .DEPTH(DEPTH_A)) ifA (.CLK(CLK), .nRST(nRST));

    imm_extend_stage #(.WORD_W(32), .IMM_W(16), .DEPTH(DEPTH_A)) dutA (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (ifA.flush),
        .in_valid  (ifA.in_valid),
        .in_ready  (ifA.in_ready),
        .instr     (ifA.instr),
        .mode      (ifA.mode),
        .out_valid (ifA.out_valid),
        .out_ready (ifA.out_ready),
        .ext_imm   (ifA.ext_imm),
        .ext_mode  (ifA.ext_mode),
        .count     (ifA.count)
    );

    imm_extend_stage #(.WORD_W(64), .IMM_W(12), .DEPTH(DEPTH_B)) dutB (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (ifA.flush),
        .in_valid  (ifA.in_valid),
        .in_ready  (inReadyB),
        .instr     (instrB),
        .mode      (ifA.mode),
        .out_valid (outValidB),
        .out_ready (ifA.out_ready),
        .ext_imm   (extImmB),
        .ext_mode  (extModeB),
        .count     (countB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: treat the immediate as a number, then scale and wrap mod 2^w.
    function automatic exp_t refEntry(input int w, input int iw,
                                      input logic [63:0] ins, input logic [1:0] m);
        exp_t e;
        longint unsigned imm;
        longint unsigned sval;
        longint unsigned res;
        imm  = ins & ((64'd1 << iw) - 64'd1);
        sval = (imm >= (64'd1 << (iw - 1))) ? imm - (64'd1 << iw) : imm;
        case (m)
            2'd0:    res = imm;
            2'd1:    res = sval;
            2'd2:    res = imm * (64'd1 << (w - iw));
            default: res = sval * 64'd4;
        endcase
        if (w < 64) res = res & ((64'd1 << w) - 64'd1);
        e.imm  = res;
        e.mode = m;
        return e;
    endfunction

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model occupancy decides acceptance; flush beats push and pop.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            qA.delete();
            qB.delete();
        end else if (ifA.flush) begin
            qA.delete();
            qB.delete();
        end else begin
            automatic bit canA = (qA.size() < DEPTH_A);
            automatic bit canB = (qB.size() < DEPTH_B);
            if (ifA.out_ready && qA.size() != 0) void'(qA.pop_front());
            if (ifA.out_ready && qB.size() != 0) void'(qB.pop_front());
            if (ifA.in_valid && canA) qA.push_back(refEntry(32, 16, {32'h0, ifA.instr}, ifA.mode));
            if (ifA.in_valid && canB) qB.push_back(refEntry(64, 12, instrB, ifA.mode));
        end
    end

    always @(negedge CLK) begin
        checkEq("A.count", 64'(ifA.count), 64'(qA.size()));
        checkEq("A.out_valid", 64'(ifA.out_valid), 64'(qA.size() != 0));
        checkEq("A.in_ready", 64'(ifA.in_ready), 64'(qA.size() < DEPTH_A));
        if (qA.size() != 0) begin
            checkEq("A.ext_imm", {32'h0, ifA.ext_imm}, qA[0].imm);
            checkEq("A.ext_mode", 64'(ifA.ext_mode), 64'(qA[0].mode));
        end
        checkEq("B.count", 64'(countB), 64'(qB.size()));
        checkEq("B.out_valid", 64'(outValidB), 64'(qB.size() != 0));
        checkEq("B.in_ready", 64'(inReadyB), 64'(qB.size() < DEPTH_B));
        if (qB.size() != 0) begin
            checkEq("B.ext_imm", extImmB, qB[0].imm);
            checkEq("B.ext_mode", 64'(extModeB), 64'(qB[0].mode));
        end
    end

    task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [1:0] m,
                                 input bit ordy, input bit fl);
        ifA.in_valid  = v;
        ifA.instr     = ins;
        ifA.mode      = ext_mode_t'(m);
        ifA.out_ready = ordy;
        ifA.flush     = fl;
        instrB        = {32'($urandom()), ins};
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expImm);
        checkEq({name, ".valid"}, 64'(ifA.out_valid), 64'd1);
        checkEq({name, ".imm"}, {32'h0, ifA.ext_imm}, {32'h0, expImm});
    endtask

    initial begin
        nRST          = 1'b0;
        ifA.flush     = 1'b0;
        ifA.in_valid  = 1'b0;
        ifA.instr     = '0;
        ifA.mode      = EXT_ZERO;
        ifA.out_ready = 1'b0;
        instrB        = '0;
        #2;
        checkEq("reset.count", 64'(ifA.count), 64'd0);
        checkEq("reset.out_valid", 64'(ifA.out_valid), 64'd0);
        checkEq("reset.in_ready", 64'(ifA.in_ready), 64'd1);
        checkEq("reset.ext_imm", {32'h0, ifA.ext_imm}, 64'd0);
        checkEq("reset.ext_mode", 64'(ifA.ext_mode), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Each mode once, consumer always ready: result visible one cycle later.
        applyStimulus(1, 32'h2401FFFC, 2'd1, 1, 0); checkOutput("sign", 32'hFFFFFFFC);
        applyStimulus(1, 32'h2401FFFC, 2'd0, 1, 0); checkOutput("zero", 32'h0000FFFC);
        applyStimulus(1, 32'h3C011234, 2'd2, 1, 0); checkOutput("lui", 32'h12340000);
        applyStimulus(1, 32'h1000FFFF, 2'd3, 1, 0); checkOutput("branchNeg", 32'hFFFFFFFC);
        applyStimulus(1, 32'h10007FFF, 2'd3, 1, 0); checkOutput("branchPos", 32'h0001FFFC);
        applyStimulus(0, 32'h0, 2'd0, 1, 0);

        // Backpressure: third push must bounce off the full buffer.
        applyStimulus(1, 32'h00000011, 2'd1, 0, 0);
        applyStimulus(1, 32'h00008022, 2'd1, 0, 0);
        checkEq("fill.count2", 64'(ifA.count), 64'd2);
        checkEq("fill.in_ready0", 64'(ifA.in_ready), 64'd0);
        applyStimulus(1, 32'h00000033, 2'd0, 0, 0);
        checkEq("fill.count_held", 64'(ifA.count), 64'd2);
        applyStimulus(0, 32'h0, 2'd0, 1, 0);
        checkEq("fill.in_ready_after_pop", 64'(ifA.in_ready), 64'd1);
        checkEq("fill.count1", 64'(ifA.count), 64'd1);
        applyStimulus(0, 32'h0, 2'd0, 1, 0);
        applyStimulus(0, 32'h0, 2'd0, 1, 0);

        // Streaming at one result per cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 32'($urandom()), 2'($urandom_range(3)), 1, 0);
            checkEq("stream.count", 64'(ifA.count), 64'd1);
        end
        applyStimulus(0, 32'h0, 2'd0, 1, 0);

        // Flush with a full buffer and a concurrent push.
        applyStimulus(1, 32'h0000AAAA, 2'd0, 0, 0);
        applyStimulus(1, 32'h0000BBBB, 2'd0, 0, 0);
        applyStimulus(1, 32'h0000CCCC, 2'd0, 0, 1);
        checkEq("flush.count", 64'(ifA.count), 64'd0);
        checkEq("flush.out_valid", 64'(ifA.out_valid), 64'd0);
        applyStimulus(1, 32'h2401FFFC, 2'd1, 1, 0);
        checkOutput("afterFlush", 32'hFFFFFFFC);
        applyStimulus(0, 32'h0, 2'd0, 1, 0);

        // Wide instance: 12-bit negative immediate across 64 bits.
        applyStimulus(1, 32'h00000800, 2'd1, 1, 0);
        checkEq("wide.valid", 64'(outValidB), 64'd1);
        checkEq("wide.sign", extImmB, 64'hFFFFFFFFFFFFF800);
        applyStimulus(0, 32'h0, 2'd0, 1, 0);

        // Asynchronous reset between edges with one entry buffered.
        applyStimulus(1, 32'h00001234, 2'd0, 0, 0);
        #2;
        nRST = 1'b0;
        #1;
        checkEq("areset.count", 64'(ifA.count), 64'd0);
        checkEq("areset.out_valid", 64'(ifA.out_valid), 64'd0);
        checkEq("areset.ext_imm", {32'h0, ifA.ext_imm}, 64'd0);
        checkEq("areset.B.count", 64'(countB), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(1, 32'h3C011234, 2'd2, 1, 0);
        checkOutput("afterReset", 32'h12340000);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(1)), 32'($urandom()), 2'($urandom_range(3)),
                          1'($urandom_range(1)), ($urandom_range(15) == 0));
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 2'd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
